// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Single-cycle multiply, 32-step restoring divide, registered write-back result.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  wb_rd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [5:0]  cnt;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        a_neg;
  logic        neg_res;
  logic        div_zero;
  logic        ovf;

  logic        a_sgn, b_sgn;
  logic        a_neg_in, b_neg_in;
  logic        neg_in;
  logic [31:0] a_in, b_in;
  logic        accept;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (op)
      3'd1, 3'd4, 3'd6: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'd2: a_sgn = 1'b1;
      default: ;
    endcase
    a_neg_in = a_sgn & rs1_data[31];
    b_neg_in = b_sgn & rs2_data[31];
    a_in = a_neg_in ? -rs1_data : rs1_data;
    b_in = b_neg_in ? -rs2_data : rs2_data;
    // Remainder takes the dividend's sign; everything else the XOR.
    neg_in = (op[2] & op[1]) ? a_neg_in
                             : (a_neg_in ^ b_neg_in);
  end

  assign accept = (state == S_IDLE) & start & ~flush;

  logic [63:0] prod;
  logic [63:0] prod_s;
  logic [31:0] mul_res;

  always_comb begin
    prod    = {32'd0, a_mag} * {32'd0, b_mag};
    prod_s  = neg_res ? -prod : prod;
    mul_res = (op_q == 3'd0) ? prod_s[31:0]
                             : prod_s[63:32];
  end

  logic [32:0] rem_sh;
  logic [32:0] rem_sub;
  logic        fits;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;

  always_comb begin
    rem_sh  = {rem, quo[31]};
    rem_sub = rem_sh - {1'b0, b_mag};
    fits    = ~rem_sub[32];
    rem_nx  = fits ? rem_sub[31:0] : rem_sh[31:0];
    quo_nx  = {quo[30:0], fits};
  end

  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] a_raw;
  logic [31:0] fix_res;

  always_comb begin
    q_s   = neg_res ? -quo : quo;
    r_s   = neg_res ? -rem : rem;
    a_raw = a_neg ? -a_mag : a_mag;
    if (div_zero)
      fix_res = op_q[1] ? a_raw : 32'hFFFF_FFFF;
    else if (ovf)
      fix_res = op_q[1] ? 32'd0 : 32'h8000_0000;
    else
      fix_res = op_q[1] ? r_s : q_s;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_d = op[2] ? S_DIV : S_MUL;
      end
      S_MUL:  state_d = S_DONE;
      S_DIV: begin
        if (cnt == 6'd31)
          state_d = S_FIX;
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      cnt      <= 6'd0;
      a_mag    <= 32'd0;
      b_mag    <= 32'd0;
      quo      <= 32'd0;
      rem      <= 32'd0;
      a_neg    <= 1'b0;
      neg_res  <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      result   <= 32'd0;
      wb_rd    <= 5'd0;
    end else if (accept) begin
      op_q     <= op;
      rd_q     <= rd_addr;
      cnt      <= 6'd0;
      a_mag    <= a_in;
      b_mag    <= b_in;
      quo      <= a_in;
      rem      <= 32'd0;
      a_neg    <= a_neg_in;
      neg_res  <= neg_in;
      div_zero <= (rs2_data == 32'd0);
      ovf      <= a_sgn & op[2]
                  & (rs1_data == 32'h8000_0000)
                  & (rs2_data == 32'hFFFF_FFFF);
    end else if (!flush) begin
      unique case (state)
        S_MUL: begin
          result <= mul_res;
          wb_rd  <= rd_q;
        end
        S_DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 6'd1;
        end
        S_FIX: begin
          result <= fix_res;
          wb_rd  <= rd_q;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
